// File: rtl/memory_access.sv
// Memory stage of the pipeline.
// Purpose: performs loads/stores on a req/ack data bus, builds byte strobes and lane-shifted
// write data, aligns and extends read data, stalls upstream while a bus transaction is in
// flight and registers the slot's results for write-back.
// Ports:
//   clk_in, rst_in          clock, asynchronous active-high reset
//   alu_result_in           effective address or forwarded ALU result
//   rs2_value_in            store data (low bytes valid)
//   rd_in, rd_write_signal_in, width_signal_in, read/write/valid/flush_signal_in
//                           execution-stage slot controls
//   mem_*_out / mem_*_in    data bus (dword-aligned address, strobes, req held until ack)
//   stall_signal_out        freeze upstream stages
//   wb_data_out, rd_out, rd_write_signal_out, valid_instr_signal_out
//                           registered write-back results
//   misaligned_signal_out   1-cycle pulse, access not naturally aligned
//   bus_error_signal_out    1-cycle pulse, bus timeout
module memory_access #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [63:0] alu_result_in,
  input  logic [63:0] rs2_value_in,
  input  logic [4:0]  rd_in,
  input  logic [2:0]  width_signal_in,
  input  logic        rd_write_signal_in,
  input  logic        read_signal_in,
  input  logic        write_signal_in,
  input  logic        valid_instr_signal_in,
  input  logic        flush_signal_in,
  output logic        mem_req_out,
  output logic        mem_we_out,
  output logic [63:0] mem_addr_out,
  output logic [63:0] mem_wdata_out,
  output logic [7:0]  mem_wstrb_out,
  input  logic [63:0] mem_rdata_in,
  input  logic        mem_ack_in,
  output logic        stall_signal_out,
  output logic [63:0] wb_data_out,
  output logic [4:0]  rd_out,
  output logic        rd_write_signal_out,
  output logic        valid_instr_signal_out,
  output logic        misaligned_signal_out,
  output logic        bus_error_signal_out
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  // Counter value on the last BUSY cycle allowed before giving up.
  localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 1);

  state_e      r_state, w_state_next;
  logic [7:0]  r_cnt;
  logic [63:0] r_alu, r_wdata, r_rdata;
  logic [7:0]  r_wstrb;
  logic [2:0]  r_width;
  logic [4:0]  r_rd_lat;
  logic        r_we, r_is_load, r_rdw_lat, r_flush, r_err;

  logic [63:0] r_wb_data;
  logic [4:0]  r_rd;
  logic        r_rd_write, r_valid, r_misaligned, r_bus_error;

  logic        w_pending, w_misaligned, w_start, w_timeout;
  logic [2:0]  w_off;
  logic [7:0]  w_wstrb;
  logic [63:0] w_wdata, w_shifted, w_load;

  assign w_off     = alu_result_in[2:0];
  assign w_pending = valid_instr_signal_in & (read_signal_in | write_signal_in) & ~flush_signal_in;
  assign w_wdata   = rs2_value_in << {w_off, 3'b000};

  always_comb begin
    w_misaligned = 1'b0;
    w_wstrb      = 8'h00;
    case (width_signal_in[1:0])
      2'b00: begin
        w_misaligned = 1'b0;
        w_wstrb      = 8'h01 << w_off;
      end
      2'b01: begin
        w_misaligned = w_off[0];
        w_wstrb      = 8'h03 << w_off;
      end
      2'b10: begin
        w_misaligned = |w_off[1:0];
        w_wstrb      = 8'h0F << w_off;
      end
      default: begin
        w_misaligned = |w_off;
        w_wstrb      = 8'hFF;
      end
    endcase
    if (!write_signal_in) w_wstrb = 8'h00;
  end

  assign w_start   = (r_state == StIdle) & w_pending & ~w_misaligned;
  // Ack wins over timeout on the same cycle.
  assign w_timeout = (r_state == StBusy) & ~mem_ack_in & (r_cnt == CntLast);

  // Read data alignment and extension from the latched request.
  assign w_shifted = r_rdata >> {r_alu[2:0], 3'b000};
  always_comb begin
    w_load = w_shifted;
    case (r_width[1:0])
      2'b00:   w_load = {{56{~r_width[2] & w_shifted[7]}}, w_shifted[7:0]};
      2'b01:   w_load = {{48{~r_width[2] & w_shifted[15]}}, w_shifted[15:0]};
      2'b10:   w_load = {{32{~r_width[2] & w_shifted[31]}}, w_shifted[31:0]};
      default: w_load = w_shifted;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (w_start) w_state_next = StBusy;
      StBusy:  if (mem_ack_in || w_timeout) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_cnt        <= '0;
      r_alu        <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_wstrb      <= '0;
      r_width      <= '0;
      r_rd_lat     <= '0;
      r_we         <= 1'b0;
      r_is_load    <= 1'b0;
      r_rdw_lat    <= 1'b0;
      r_flush      <= 1'b0;
      r_err        <= 1'b0;
      r_wb_data    <= '0;
      r_rd         <= '0;
      r_rd_write   <= 1'b0;
      r_valid      <= 1'b0;
      r_misaligned <= 1'b0;
      r_bus_error  <= 1'b0;
    end else begin
      r_misaligned <= 1'b0;
      r_bus_error  <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_start) begin
            // Capture the request so the bus sees stable values while BUSY;
            // pipeline outputs hold through the stall.
            r_alu     <= alu_result_in;
            r_wdata   <= w_wdata;
            r_wstrb   <= w_wstrb;
            r_we      <= write_signal_in;
            r_is_load <= ~write_signal_in;
            r_width   <= width_signal_in;
            r_rd_lat  <= rd_in;
            r_rdw_lat <= rd_write_signal_in;
            r_flush   <= 1'b0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
          end else begin
            r_wb_data    <= alu_result_in;
            r_rd         <= rd_in;
            r_rd_write   <= valid_instr_signal_in & rd_write_signal_in & ~flush_signal_in &
                            ~(w_pending & w_misaligned);
            r_valid      <= valid_instr_signal_in & ~flush_signal_in;
            r_misaligned <= w_pending & w_misaligned;
          end
        end
        StBusy: begin
          // A flush cannot abort the bus op; remember it for the DONE slot.
          if (flush_signal_in) begin
            r_flush    <= 1'b1;
            r_rd_write <= 1'b0;
            r_valid    <= 1'b0;
          end
          if (mem_ack_in) begin
            r_rdata <= mem_rdata_in;
          end else if (w_timeout) begin
            r_err       <= 1'b1;
            r_bus_error <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        StDone: begin
          r_wb_data  <= (r_is_load & ~r_err) ? w_load : r_alu;
          r_rd       <= r_rd_lat;
          r_rd_write <= r_rdw_lat & r_is_load & ~r_err & ~r_flush & ~flush_signal_in;
          r_valid    <= ~r_flush & ~flush_signal_in;
        end
        default: ;
      endcase
    end
  end

  assign mem_req_out            = (r_state == StBusy);
  assign mem_we_out             = r_we;
  assign mem_addr_out           = {r_alu[63:3], 3'b000};
  assign mem_wdata_out          = r_wdata;
  assign mem_wstrb_out          = r_wstrb;
  assign stall_signal_out       = w_start | (r_state == StBusy);
  assign wb_data_out            = r_wb_data;
  assign rd_out                 = r_rd;
  assign rd_write_signal_out    = r_rd_write;
  assign valid_instr_signal_out = r_valid;
  assign misaligned_signal_out  = r_misaligned;
  assign bus_error_signal_out   = r_bus_error;

endmodule
